// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: legal hex glyphs, blank pattern and scan FSM states.
package seg7_pkg;

  // Active-high glyphs for hex 0..F on bits 6..0 (a = bit6 .. g = bit0).
  localparam logic [6:0] SegHex [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // All segments plus dp lit; used by encoders that need a blank/test glyph.
  localparam logic [7:0] SegBlank = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } scan_state_e;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational decode of a 7-bit segment glyph into its hex value plus a legality flag.
module seg_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] hex,
  output logic       legal
);

  // Table search; glyphs are unique so at most one entry matches.
  always_comb begin
    hex   = 4'h0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SegHex[i]) begin
        hex   = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Observes a multiplexed seven-segment display bus, debounces each digit slot and
// reassembles complete frames of hex digits.
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    clr_err,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_valid,
  output logic                    frame_ok,
  output logic                    err_pattern,
  output logic                    err_multi
);

  localparam logic [7:0] CntLast = 8'(STABLE_CYCLES - 1);

  // Sample stage and its one-cycle-delayed copy for change detection.
  logic [NUM_DIGITS-1:0] an_q, an_prev_q;
  logic [7:0]            seg_q, seg_prev_q;

  scan_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dvalid_q, dvalid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    fvalid_q, fvalid_d;
  logic                    fok_q, fok_d;
  logic                    err_pat_q, err_pat_d;
  logic                    err_multi_q, err_multi_d;

  logic       changed, commit, multi_hit;
  logic [3:0] hex;
  logic       legal;

  seg_to_hex u_seg_to_hex (
    .pattern (seg_q[6:0]),
    .hex     (hex),
    .legal   (legal)
  );

  assign changed = {an_q, seg_q} != {an_prev_q, seg_prev_q};

  // Stability FSM: a run of identical samples commits exactly once.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    commit    = 1'b0;
    multi_hit = 1'b0;
    if (changed) begin
      cnt_d   = 8'd0;
      state_d = (an_q != '0) ? StSettle : StIdle;
    end else begin
      case (state_q)
        StSettle: begin
          if (cnt_q == CntLast) begin
            state_d = StHold;
            if ($onehot(an_q)) begin
              commit = 1'b1;
            end else begin
              multi_hit = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Digit capture, frame assembly and sticky error flags.
  always_comb begin
    digits_d    = digits_q;
    dvalid_d    = dvalid_q;
    seen_d      = seen_q;
    value_d     = value_q;
    fvalid_d    = 1'b0;
    fok_d       = fok_q;
    // Mask filled on the previous edge: publish the frame now.
    if (&seen_q) begin
      value_d  = digits_q;
      fok_d    = &dvalid_q;
      fvalid_d = 1'b1;
      seen_d   = '0;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (commit && an_q[i]) begin
        digits_d[4*i +: 4] = legal ? hex : 4'h0;
        dvalid_d[i]        = legal;
        seen_d[i]          = 1'b1;
      end
    end
    err_pat_d   = (commit && !legal) ? 1'b1 : (clr_err ? 1'b0 : err_pat_q);
    err_multi_d = multi_hit ? 1'b1 : (clr_err ? 1'b0 : err_multi_q);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q        <= '0;
      an_prev_q   <= '0;
      seg_q       <= 8'h00;
      seg_prev_q  <= 8'h00;
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      digits_q    <= '0;
      value_q     <= '0;
      dvalid_q    <= '0;
      seen_q      <= '0;
      fvalid_q    <= 1'b0;
      fok_q       <= 1'b0;
      err_pat_q   <= 1'b0;
      err_multi_q <= 1'b0;
    end else begin
      an_q        <= an;
      an_prev_q   <= an_q;
      seg_q       <= seg;
      seg_prev_q  <= seg_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      value_q     <= value_d;
      dvalid_q    <= dvalid_d;
      seen_q      <= seen_d;
      fvalid_q    <= fvalid_d;
      fok_q       <= fok_d;
      err_pat_q   <= err_pat_d;
      err_multi_q <= err_multi_d;
    end
  end

  assign value       = value_q;
  assign digit_valid = dvalid_q;
  assign frame_valid = fvalid_q;
  assign frame_ok    = fok_q;
  assign err_pattern = err_pat_q;
  assign err_multi   = err_multi_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized and directed bench for seg_scan_decoder against a run-length reference model.
module tb_seg_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    seg = 8'h00;
  logic [ND-1:0] an = '0;
  logic          clr_err = 1'b0;
  logic [4*ND-1:0] value;
  logic [ND-1:0] digit_valid;
  logic          frame_valid, frame_ok, err_pattern, err_multi;

  seg_scan_decoder #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .clr_err     (clr_err),
    .value       (value),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .frame_ok    (frame_ok),
    .err_pattern (err_pattern),
    .err_multi   (err_multi)
  );

  always #5 clk = ~clk;

  logic [6:0] pats [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  int n_checks = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;
  bit rnd_clr  = 0;

  // Reference model: a commit happens when a run of identical samples reaches SC+1.
  int unsigned     run_len;
  logic [11:0]     run_val;
  logic [ND-1:0]   m_seen;
  logic [4*ND-1:0] m_digits, m_value;
  logic [ND-1:0]   m_dvalid;
  logic            m_fv, m_fok, m_ep, m_em;
  bit              m_flush_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hex_of(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (pats[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    run_len = 1000; run_val = '0; m_seen = '0; m_digits = '0; m_value = '0;
    m_dvalid = '0; m_fv = 0; m_fok = 0; m_ep = 0; m_em = 0; m_flush_pend = 0;
  endtask

  task automatic model_edge();
    bit set_p, set_m;
    logic [ND-1:0] ra;
    int h, idx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_fv = 0;
    if (m_flush_pend) begin
      m_value = m_digits; m_fok = &m_dvalid; m_fv = 1; m_seen = '0; m_flush_pend = 0;
    end
    set_p = 0; set_m = 0;
    if (run_len == SC + 1) begin
      ra = run_val[11:8];
      if ($countones(ra) == 1) begin
        idx = 0;
        for (int i = 0; i < ND; i++) if (ra[i]) idx = i;
        h = hex_of(run_val[6:0]);
        m_digits[4*idx +: 4] = (h >= 0) ? 4'(h) : 4'h0;
        m_dvalid[idx] = (h >= 0);
        if (h < 0) set_p = 1;
        m_seen[idx] = 1'b1;
        if (&m_seen) m_flush_pend = 1;
      end else if (ra != '0) begin
        set_m = 1;
      end
    end
    m_ep = set_p ? 1'b1 : (clr_err ? 1'b0 : m_ep);
    m_em = set_m ? 1'b1 : (clr_err ? 1'b0 : m_em);
    if ({an, seg} == run_val) run_len++;
    else begin
      run_val = {an, seg};
      run_len = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("value", 32'(value), 32'(m_value));
    check_eq("digit_valid", 32'(digit_valid), 32'(m_dvalid));
    check_eq("frame_valid", 32'(frame_valid), 32'(m_fv));
    check_eq("frame_ok", 32'(frame_ok), 32'(m_fok));
    check_eq("err_pattern", 32'(err_pattern), 32'(m_ep));
    check_eq("err_multi", 32'(err_multi), 32'(m_em));
    if (frame_valid) fv_cnt++;
  endtask

  task automatic hold(input logic [ND-1:0] a, input logic [7:0] s, input int n);
    an = a; seg = s;
    for (int i = 0; i < n; i++) begin
      clr_err = rnd_clr && ($urandom_range(0, 19) == 0);
      step();
    end
    clr_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    check_eq("rst_value", 32'(value), 32'h0);
    check_eq("rst_flags", 32'({digit_valid, frame_valid, frame_ok, err_pattern, err_multi}), 32'h0);

    // Single digit commit, no frame yet.
    fv_cnt = 0;
    hold(4'b0001, 8'h30, 4);
    check_eq("d0_early", 32'(digit_valid[0]), 32'h0);
    hold(4'b0001, 8'h30, 2);
    check_eq("d0_valid", 32'(digit_valid[0]), 32'h1);
    hold(4'b0000, 8'h00, 3);
    check_eq("d0_no_frame", 32'(fv_cnt), 32'h0);

    // Full scan 1,2,3,4.
    fv_cnt = 0;
    hold(4'b0001, 8'h30, 6);
    hold(4'b0010, 8'h6D, 6);
    hold(4'b0100, 8'h79, 6);
    hold(4'b1000, 8'h33, 6);
    hold(4'b0000, 8'h00, 4);
    check_eq("scan_fv_cnt", 32'(fv_cnt), 32'h1);
    check_eq("scan_value", 32'(value), 32'h4321);
    check_eq("scan_ok", 32'(frame_ok), 32'h1);

    // Illegal glyph in slot 2, then clear.
    hold(4'b0001, 8'hB0, 6);
    hold(4'b0010, 8'h6D, 6);
    hold(4'b0100, 8'h00, 6);
    hold(4'b1000, 8'h33, 6);
    hold(4'b0000, 8'h00, 3);
    check_eq("bad_err", 32'(err_pattern), 32'h1);
    check_eq("bad_dv2", 32'(digit_valid[2]), 32'h0);
    check_eq("bad_ok", 32'(frame_ok), 32'h0);
    check_eq("bad_value", 32'(value), 32'h4021);
    clr_err = 1;
    step();
    clr_err = 0;
    check_eq("clr_err", 32'(err_pattern), 32'h0);

    // Multiple an bits set, then fast toggling.
    do_reset();
    hold(4'b0011, 8'h30, 8);
    check_eq("multi_err", 32'(err_multi), 32'h1);
    check_eq("multi_nocommit", 32'(digit_valid), 32'h0);
    for (int i = 0; i < 10; i++) hold(4'b0001, (i % 2 == 0) ? 8'h30 : 8'h6D, 2);
    check_eq("toggle_nocommit", 32'(digit_valid), 32'h0);

    // Reset after three of four digits.
    do_reset();
    hold(4'b0001, 8'h30, 6);
    hold(4'b0010, 8'h6D, 6);
    hold(4'b0100, 8'h79, 6);
    check_eq("partial_dv", 32'(digit_valid), 32'h7);
    do_reset();
    check_eq("partial_rst", 32'({value, digit_valid, frame_valid, frame_ok, err_pattern, err_multi}),
             32'h0);
    fv_cnt = 0;
    hold(4'b0001, 8'h7E, 6);
    hold(4'b0010, 8'h47, 6);
    hold(4'b1000, 8'h5B, 6);
    hold(4'b0000, 8'h00, 4);
    check_eq("partial_no_frame", 32'(fv_cnt), 32'h0);
    hold(4'b0100, 8'h77, 6);
    hold(4'b0000, 8'h00, 4);
    check_eq("post_rst_fv_cnt", 32'(fv_cnt), 32'h1);
    check_eq("post_rst_value", 32'(value), 32'h5AF0);

    // Randomized traffic.
    rnd_clr = 1;
    for (int n = 0; n < 400; n++) begin
      logic [ND-1:0] a;
      logic [7:0] s;
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 70) a = ND'(1 << $urandom_range(0, ND - 1));
      else if (sel < 85) a = '0;
      else a = ND'($urandom_range(0, (1 << ND) - 1));
      if ($urandom_range(0, 99) < 80) s = {1'($urandom_range(0, 1)), pats[$urandom_range(0, 15)]};
      else s = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) do_reset();
      hold(a, s, $urandom_range(1, 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digit positions observed.
REQ-002 Parameter STABLE_CYCLES, default 4, consecutive identical samples required before a digit is committed; legal range 2..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 seg  input  8  segment bus, active-high; bit7 unused (dp), bits6..0 = segments a..g (a = bit6, g = bit0).
REQ-006 an  input  NUM_DIGITS  digit select, active-high, one-hot when a digit is driven; all-zero = blanking.
REQ-007 clr_err  input  1  synchronous clear of sticky error flags.
REQ-008 value  output  4*NUM_DIGITS  last completed frame, digit i in bits [4i+3:4i].
REQ-009 digit_valid  output  NUM_DIGITS  per-digit flag: last committed pattern for digit i was legal.
REQ-010 frame_valid  output  1  one-cycle pulse when value is updated.
REQ-011 frame_ok  output  1  registered with frame_valid: every digit in the completed frame was legal.
REQ-012 err_pattern  output  1  sticky: an illegal segment pattern was committed.
REQ-013 err_multi  output  1  sticky: a stable sample had more than one an bit set.

Function
REQ-014 seg and an SHALL be registered once (sample stage) before any comparison.
REQ-015 Legal patterns (bits6..0): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 B=1F C=4E D=3D E=4F F=47; bit7 SHALL be ignored; any other pattern is illegal.
REQ-016 FSM states: IDLE (blank or just changed), SETTLE (counting), HOLD (committed, waiting for change).
REQ-017 Any difference between current and previous sample {an,seg} SHALL reset the stability counter to 0 and force IDLE -> SETTLE (or SETTLE if an nonzero, IDLE if an all-zero).
REQ-018 In SETTLE, counter increments per identical sample; when counter reaches STABLE_CYCLES-1 the FSM SHALL commit once and enter HOLD.
REQ-019 Latency: {an,seg} held constant from edge k -> commit registers updated at edge k+STABLE_CYCLES+1.
REQ-020 Commit with one-hot an (index i): internal digit i <= decoded hex; digit_valid[i] <= legal; illegal -> digit value 0, digit_valid[i]=0, err_pattern set.
REQ-021 Stable an all-zero: no commit, no error. Stable an with >1 bit set: no commit, err_multi set.
REQ-022 HOLD SHALL NOT recommit the same unchanged sample, regardless of duration.
REQ-023 A seen mask records digits committed since last frame; when mask becomes all-ones, at the next edge value <= internal digits, frame_ok <= AND of digit_valid, frame_valid pulses 1 cycle, mask clears.
REQ-024 Recommit of an already-seen digit before frame completion SHALL overwrite its internal value without affecting the mask.
REQ-025 clr_err concurrent with a new error: set wins.
REQ-026 value SHALL hold between frames; frame_valid never asserts two consecutive cycles.

Reset
REQ-027 rst_n low at a clock edge: FSM=IDLE, counter=0, samples=0, seen mask=0, internal digits=0, value=0, digit_valid=0, frame_valid=0, frame_ok=0, err_pattern=0, err_multi=0.
REQ-028 Reset mid-SETTLE or mid-frame SHALL discard partial progress; no frame_valid is produced from pre-reset commits.

Structure
REQ-029 Shared package seg7_pkg SHALL hold the 16 legal pattern constants, blank pattern 8'hFF, and FSM state type; reused by any segment encoder.
REQ-030 One combinational sub-module seg_to_hex (pattern[6:0] -> hex[3:0], legal) SHALL be instantiated once on the sample register.

Verification
REQ-031 an=0001 seg=8'h30 held 5 cycles (STABLE_CYCLES=4) -> digit 0 committed =1 at edge k+5, digit_valid[0]=1, no frame_valid.
REQ-032 Scan 4 digits 1,2,3,4 (an 0001..1000, patterns 30,6D,79,33) each 6 cycles -> single frame_valid, value=16'h4321, frame_ok=1.
REQ-033 Digit 2 pattern 8'h00 in a frame -> err_pattern=1, digit_valid[2]=0, frame_ok=0; clr_err -> err_pattern=0.
REQ-034 an=0011 held 8 cycles -> err_multi=1, no commit; pattern toggling every 2 cycles -> no commit ever.
REQ-035 rst_n low after 3 of 4 digits committed -> all outputs 0; next full scan yields exactly one frame_valid.
